// File: rtl/ip_hdr_seq_pkg.sv
// ip_hdr_seq_pkg
//   Shared constants, sequencer state type and checksum fold helper for the
//   IPv4 header sequencer (ip_hdr_seq) and its checksum pipe (ip_cks_pipe).
//   No ports.
package ip_hdr_seq_pkg;

    localparam logic [15:0] IP_VER_IHL_TOS = 16'h4500;  // version 4, IHL 5, TOS 0
    localparam logic [15:0] IP_FLAG_FRAG   = 16'h4000;  // DF set, fragment offset 0
    localparam int unsigned IP_HDR_WORDS   = 10;
    localparam logic [3:0]  IP_LAST_WORD   = 4'(IP_HDR_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_FOLD = 2'd2,
        ST_SEND = 2'd3
    } seq_state_t;

    // One's-complement fold of a 32-bit sum down to 16 bits, then invert.
    // The second add re-injects the carry out of the first one; it cannot
    // overflow again because f[15:0] <= 16'hFFFE whenever f[16] is set.
    function automatic logic [15:0] cks_fold(input logic [31:0] s32);
        logic [16:0] f;
        logic [15:0] f2;
        f  = {1'b0, s32[31:16]} + {1'b0, s32[15:0]};
        f2 = f[15:0] + {15'b0, f[16]};
        return ~f2;
    endfunction

endpackage

// File: rtl/ip_hdr_seq_cks_pipe.sv
// ip_cks_pipe
//   Two-stage IPv4 header checksum: stage 1 sums the ten header words into a
//   32-bit accumulator, stage 2 folds and inverts it.
//   Ports:
//     clk, rst    rising-edge clock, synchronous active-high reset
//     i_start     pulse: sample i_len/i_id and start a new checksum
//     i_len       IP total length
//     i_id        identification value
//     o_cks       checksum result (valid while o_cks_vld)
//     o_cks_vld   high from the cycle after the fold until the next i_start
module ip_cks_pipe
    import ip_hdr_seq_pkg::*;
#(
    parameter logic [31:0] SRC_IP = 32'hC0A80002,
    parameter logic [31:0] DST_IP = 32'hC0A80003,
    parameter logic [7:0]  TTL    = 8'h80,
    parameter logic [7:0]  PROTO  = 8'h11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_len,
    input  logic [15:0] i_id,
    output logic [15:0] o_cks,
    output logic        o_cks_vld
);

    logic [31:0] w_s32;
    logic [31:0] r_s32;
    logic        r_sum_vld;
    logic [15:0] r_cks;
    logic        r_cks_vld;

    // Checksum field itself is taken as zero.
    always_comb begin
        w_s32 = {16'b0, IP_VER_IHL_TOS}
              + {16'b0, i_len}
              + {16'b0, i_id}
              + {16'b0, IP_FLAG_FRAG}
              + {16'b0, TTL, PROTO}
              + {16'b0, SRC_IP[31:16]}
              + {16'b0, SRC_IP[15:0]}
              + {16'b0, DST_IP[31:16]}
              + {16'b0, DST_IP[15:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s32     <= '0;
            r_sum_vld <= 1'b0;
            r_cks     <= '0;
            r_cks_vld <= 1'b0;
        end else begin
            r_sum_vld <= i_start;
            if (i_start) begin
                r_s32 <= w_s32;
            end
            if (r_sum_vld) begin
                r_cks <= cks_fold(r_s32);
            end
            if (i_start) begin
                r_cks_vld <= 1'b0;
            end else if (r_sum_vld) begin
                r_cks_vld <= 1'b1;
            end
        end
    end

    assign o_cks     = r_cks;
    assign o_cks_vld = r_cks_vld;

endmodule

// File: rtl/ip_hdr_seq.sv
// ip_hdr_seq
//   Builds one 20-byte IPv4 header per request and streams it as ten 16-bit
//   big-endian words. Owns the running identification counter.
//   Ports:
//     clk, rst    rising-edge clock, synchronous active-high reset
//     req_valid   requester has a header to build
//     req_ready   idle and able to accept (transfer on req_valid&req_ready)
//     req_len     IP total length, sampled on request transfer
//     hdr_valid   hdr_data valid
//     hdr_ready   consumer accepts word (transfer on hdr_valid&hdr_ready)
//     hdr_data    current header word
//     hdr_last    high with the tenth word
//     hdr_id      identification of the header being or last sent
//     busy        not idle
module ip_hdr_seq
    import ip_hdr_seq_pkg::*;
#(
    parameter logic [31:0] SRC_IP  = 32'hC0A80002,
    parameter logic [31:0] DST_IP  = 32'hC0A80003,
    parameter logic [7:0]  TTL     = 8'h80,
    parameter logic [7:0]  PROTO   = 8'h11,
    parameter logic [15:0] ID_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_len,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [15:0] hdr_data,
    output logic        hdr_last,
    output logic [15:0] hdr_id,
    output logic        busy
);

    seq_state_t  r_state;
    seq_state_t  w_next;
    logic [15:0] r_len;
    logic [15:0] r_id;
    logic [15:0] r_hdr_id;
    logic [3:0]  r_w;

    logic        w_accept;
    logic        w_hdr_xfer;
    logic        w_last_xfer;
    logic [15:0] w_word;
    logic [15:0] w_cks;
    logic        w_cks_vld;

    ip_cks_pipe #(
        .SRC_IP (SRC_IP),
        .DST_IP (DST_IP),
        .TTL    (TTL),
        .PROTO  (PROTO)
    ) u_cks (
        .clk       (clk),
        .rst       (rst),
        .i_start   (r_state == ST_SUM),
        .i_len     (r_len),
        .i_id      (r_id),
        .o_cks     (w_cks),
        .o_cks_vld (w_cks_vld)
    );

    always_comb begin
        case (r_w)
            4'd0:    w_word = IP_VER_IHL_TOS;
            4'd1:    w_word = r_len;
            4'd2:    w_word = r_id;
            4'd3:    w_word = IP_FLAG_FRAG;
            4'd4:    w_word = {TTL, PROTO};
            4'd5:    w_word = w_cks;
            4'd6:    w_word = SRC_IP[31:16];
            4'd7:    w_word = SRC_IP[15:0];
            4'd8:    w_word = DST_IP[31:16];
            4'd9:    w_word = DST_IP[15:0];
            default: w_word = '0;
        endcase
    end

    // Next state and outputs. req_ready is masked by rst so nothing is
    // accepted in the reset cycle itself.
    always_comb begin
        w_next      = r_state;
        req_ready   = 1'b0;
        busy        = 1'b1;
        hdr_valid   = 1'b0;
        hdr_data    = '0;
        hdr_last    = 1'b0;
        w_accept    = 1'b0;
        w_hdr_xfer  = 1'b0;
        w_last_xfer = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy      = 1'b0;
                req_ready = !rst;
                w_accept  = req_valid && !rst;
                if (w_accept) begin
                    w_next = ST_SUM;
                end
            end
            ST_SUM: begin
                w_next = ST_FOLD;
            end
            ST_FOLD: begin
                w_next = ST_SEND;
            end
            ST_SEND: begin
                hdr_valid   = w_cks_vld;
                hdr_data    = w_cks_vld ? w_word : '0;
                hdr_last    = w_cks_vld && (r_w == IP_LAST_WORD);
                w_hdr_xfer  = hdr_valid && hdr_ready;
                w_last_xfer = w_hdr_xfer && (r_w == IP_LAST_WORD);
                if (w_last_xfer) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_id     <= ID_INIT;
            r_hdr_id <= ID_INIT;
            r_w      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_len    <= req_len;
                r_hdr_id <= r_id;
                r_w      <= '0;
            end
            if (w_hdr_xfer) begin
                if (w_last_xfer) begin
                    r_w  <= '0;
                    r_id <= r_id + 16'd1;
                end else begin
                    r_w <= r_w + 4'd1;
                end
            end
        end
    end

    assign hdr_id = r_hdr_id;

endmodule

// File: tb/tb_ip_hdr_seq.sv
// tb_ip_hdr_seq
//   Randomised self-checking bench for ip_hdr_seq. Two instances share all
//   inputs: one with default ID_INIT, one with ID_INIT=16'hFFFF so the id
//   wrap is exercised. A behavioural model predicts every output each cycle.
module tb_ip_hdr_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_len;
    logic        hdr_ready;

    logic        req_ready,   req_ready_b;
    logic        hdr_valid,   hdr_valid_b;
    logic [15:0] hdr_data,    hdr_data_b;
    logic        hdr_last,    hdr_last_b;
    logic [15:0] hdr_id,      hdr_id_b;
    logic        busy,        busy_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ip_hdr_seq u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_len   (req_len),
        .hdr_valid (hdr_valid),
        .hdr_ready (hdr_ready),
        .hdr_data  (hdr_data),
        .hdr_last  (hdr_last),
        .hdr_id    (hdr_id),
        .busy      (busy)
    );

    ip_hdr_seq #(.ID_INIT(16'hFFFF)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready_b),
        .req_len   (req_len),
        .hdr_valid (hdr_valid_b),
        .hdr_ready (hdr_ready),
        .hdr_data  (hdr_data_b),
        .hdr_last  (hdr_last_b),
        .hdr_id    (hdr_id_b),
        .busy      (busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference checksum: one's-complement sum with end-around carry.
    function automatic logic [15:0] ref_cks(input logic [15:0] len, input logic [15:0] id);
        int unsigned s;
        s = 32'h4500 + 32'(len) + 32'(id) + 32'h4000 + 32'h8011
          + 32'hC0A8 + 32'h0002 + 32'hC0A8 + 32'h0003;
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return ~(16'(s));
    endfunction

    function automatic logic [15:0] ref_word(input int idx, input logic [15:0] len,
                                             input logic [15:0] id);
        case (idx)
            0: return 16'h4500;
            1: return len;
            2: return id;
            3: return 16'h4000;
            4: return 16'h8011;
            5: return ref_cks(len, id);
            6: return 16'hC0A8;
            7: return 16'h0002;
            8: return 16'hC0A8;
            default: return 16'h0003;
        endcase
    endfunction

    // ---------------- reference model / monitor ----------------
    int          cyc        = 0;
    bit          m_active   = 0;
    int          m_idx      = 0;
    int          m_acc_cyc  = 0;
    int          m_last_cyc = 0;
    int          m_hdr_num  = 0;
    int          m_hold_acc = 0;
    logic [15:0] m_len      = '0;
    logic [15:0] m_id_a     = 16'h0000;
    logic [15:0] m_id_b     = 16'hFFFF;
    logic [15:0] m_hid_a    = 16'h0000;
    logic [15:0] m_hid_b    = 16'hFFFF;
    bit          hold_mode  = 0;
    bit          rnd_mode   = 0;

    always @(negedge clk) begin
        bit m_idle;
        bit exp_v;
        cyc++;
        if (!hold_mode) m_hold_acc = 0;
        if (rst) begin
            chk("rst_req_ready",   32'(req_ready),   0);
            chk("rst_req_ready_b", 32'(req_ready_b), 0);
            m_active = 0;
            m_idx    = 0;
            m_id_a   = 16'h0000;
            m_id_b   = 16'hFFFF;
            m_hid_a  = 16'h0000;
            m_hid_b  = 16'hFFFF;
        end else begin
            m_idle = !m_active;
            exp_v  = m_active && (cyc - m_acc_cyc >= 3);
            chk("req_ready",   32'(req_ready),   32'(m_idle));
            chk("req_ready_b", 32'(req_ready_b), 32'(m_idle));
            chk("busy",        32'(busy),        32'(m_active));
            chk("busy_b",      32'(busy_b),      32'(m_active));
            chk("hdr_valid",   32'(hdr_valid),   32'(exp_v));
            chk("hdr_valid_b", 32'(hdr_valid_b), 32'(exp_v));
            chk("hdr_id",      32'(hdr_id),      32'(m_hid_a));
            chk("hdr_id_b",    32'(hdr_id_b),    32'(m_hid_b));
            if (exp_v) begin
                chk("hdr_data",   32'(hdr_data),   32'(ref_word(m_idx, m_len, m_hid_a)));
                chk("hdr_data_b", 32'(hdr_data_b), 32'(ref_word(m_idx, m_len, m_hid_b)));
                chk("hdr_last",   32'(hdr_last),   32'(m_idx == 9));
                chk("hdr_last_b", 32'(hdr_last_b), 32'(m_idx == 9));
                if (m_hdr_num == 0 && m_idx == 5) chk("cks_first",  32'(hdr_data), 32'h797B);
                if (m_hdr_num == 1 && m_idx == 2) chk("id_second",  32'(hdr_data), 32'h0001);
                if (m_hdr_num == 1 && m_idx == 5) chk("cks_second", 32'(hdr_data), 32'h797A);
                if (hdr_ready) begin
                    m_idx++;
                    if (m_idx == 10) begin
                        m_active   = 0;
                        m_idx      = 0;
                        m_id_a     = m_id_a + 16'd1;
                        m_id_b     = m_id_b + 16'd1;
                        m_last_cyc = cyc;
                        m_hdr_num++;
                    end
                end
            end else begin
                chk("idle_data", 32'(hdr_data), 0);
                chk("idle_last", 32'(hdr_last), 0);
            end
            if (req_valid && m_idle) begin
                if (hold_mode && m_hold_acc > 0) chk("b2b_gap", 32'(cyc - m_last_cyc), 1);
                if (hold_mode) m_hold_acc++;
                m_active  = 1;
                m_idx     = 0;
                m_acc_cyc = cyc;
                m_len     = req_len;
                m_hid_a   = m_id_a;
                m_hid_b   = m_id_b;
            end
        end
    end

    // Consumer back-pressure.
    initial begin
        hdr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            hdr_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic [15:0] len);
        bit ok;
        ok        = 0;
        req_len   = len;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready && !rst) ok = 1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_len   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed: two default-length headers, consumer always ready.
        do_req(16'h001C);
        wait_idle();
        do_req(16'h001C);
        wait_idle();

        // Random lengths and random back-pressure.
        rnd_mode = 1;
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_req(16'($urandom_range(0, 65535)));
            wait_idle();
        end
        do_req(16'hFFFF);
        wait_idle();
        do_req(16'h0000);
        wait_idle();

        // req_valid held high: one accept per header, next one right after last word.
        rnd_mode  = 0;
        hold_mode = 1;
        req_len   = 16'h0123;
        req_valid = 1'b1;
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk);
                if (m_hold_acc >= 3) ok = 1;
            end
            if (!ok) chk("hold_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle();
        hold_mode = 0;

        // Reset during word 4 aborts the header and restores ID_INIT.
        do_req(16'h0040);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_req(16'h001C);
        wait_idle();

        // A last randomised header after the reset.
        rnd_mode = 1;
        do_req(16'($urandom_range(0, 65535)));
        wait_idle();
        rnd_mode = 0;

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
